timer_ctrl: RTL and testbench

- Programmable interval-timer controller that sequences an internal period counter.
- Accepts start/stop/pause commands, counts a latched period, and emits a one-cycle tick at each period boundary.
- Supports one-shot and periodic modes; periodic mode runs a bounded or unbounded number of repeats.
- Sits between a control/CSR layer and consumers needing periodic strobes (sampling enables, watchdog kicks, baud gating).

---
 rtl/timer_pkg.sv | 15 +
 rtl/period_counter.sv | 37 +++
 rtl/timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_timer_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer controller: FSM state encoding
// and mode selection values.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/period_counter.sv
// Free-running period counter: counts up while enabled and wraps to zero
// after reaching the terminal value, flagging the wrap combinationally.
module period_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             a_rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] val,
  output logic             wrap
);

  logic at_term_s;

  assign at_term_s = (val == term);
  assign wrap      = en && at_term_s;

  // Count register: clear dominates, otherwise step or wrap when enabled.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      val <= {WIDTH{1'b0}};
    end else if (clr) begin
      val <= {WIDTH{1'b0}};
    end else if (en) begin
      if (at_term_s) begin
        val <= {WIDTH{1'b0}};
      end else begin
        val <= val + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: one-shot or periodic, with pause/stop control,
// per-period tick strobe and bounded or unbounded repeat count.
module timer_ctrl #(
  parameter int WIDTH     = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 a_rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 pause_i,
  input  logic                 mode_i,
  input  logic [WIDTH-1:0]     period_i,
  input  logic [REP_WIDTH-1:0] repeat_i,
  output logic                 busy_o,
  output logic                 tick_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [WIDTH-1:0]     val_o,
  output logic [REP_WIDTH-1:0] rep_cnt_o
);

  import timer_pkg::*;

  state_e               state_r;
  logic [WIDTH-1:0]     period_r;
  logic                 mode_r;
  logic [REP_WIDTH-1:0] repeat_r;
  logic [REP_WIDTH-1:0] rep_cnt_r;
  logic                 err_r;

  logic [WIDTH-1:0]     term_s;
  logic [WIDTH-1:0]     val_s;
  logic                 en_s;
  logic                 clr_s;
  logic                 wrap_s;
  logic [REP_WIDTH-1:0] rep_next_s;
  logic                 last_tick_s;

  period_counter #(.WIDTH(WIDTH)) u_period_counter (
    .clk_i   (clk_i),
    .a_rst_i (a_rst_i),
    .clr     (clr_s),
    .en      (en_s),
    .term    (term_s),
    .val     (val_s),
    .wrap    (wrap_s)
  );

  // Counter control: stop and pause both freeze the count in the same cycle,
  // so a tick coincident with either is never emitted.
  always_comb begin
    term_s = period_r - WIDTH'(1);
    en_s   = 1'b0;
    clr_s  = 1'b1;
    case (state_r)
      ST_RUN: begin
        en_s  = !stop_i && !pause_i;
        clr_s = stop_i;
      end
      ST_PAUSE: begin
        en_s  = 1'b0;
        clr_s = stop_i;
      end
      ST_IDLE, ST_DONE: begin
        en_s  = 1'b0;
        clr_s = 1'b1;
      end
      default: begin
        en_s  = 1'b0;
        clr_s = 1'b1;
      end
    endcase
  end

  // Saturating tick count and completion decision for the current tick.
  always_comb begin
    if (rep_cnt_r == {REP_WIDTH{1'b1}}) begin
      rep_next_s = rep_cnt_r;
    end else begin
      rep_next_s = rep_cnt_r + REP_WIDTH'(1);
    end
    last_tick_s = (mode_r == MODE_ONESHOT) ||
                  ((mode_r == MODE_PERIODIC) &&
                   (repeat_r != {REP_WIDTH{1'b0}}) &&
                   (rep_next_s == repeat_r));
  end

  // Sequencing FSM with command latching, repeat counting and error strobe.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_r   <= ST_IDLE;
      period_r  <= {WIDTH{1'b0}};
      mode_r    <= MODE_ONESHOT;
      repeat_r  <= {REP_WIDTH{1'b0}};
      rep_cnt_r <= {REP_WIDTH{1'b0}};
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            if (period_i != {WIDTH{1'b0}}) begin
              period_r  <= period_i;
              mode_r    <= mode_i;
              repeat_r  <= repeat_i;
              rep_cnt_r <= {REP_WIDTH{1'b0}};
              state_r   <= ST_RUN;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_r <= ST_IDLE;
          end else if (pause_i) begin
            state_r <= ST_PAUSE;
          end else if (wrap_s) begin
            rep_cnt_r <= rep_next_s;
            if (last_tick_s) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (stop_i) begin
            state_r <= ST_IDLE;
          end else if (!pause_i) begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (state_r == ST_RUN) || (state_r == ST_PAUSE);
  assign done_o    = (state_r == ST_DONE);
  assign err_o     = err_r;
  assign tick_o    = wrap_s;
  assign val_o     = val_s;
  assign rep_cnt_o = rep_cnt_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed table, multi-cycle corner
// sequences and randomized commands against a behavioural timer model.
module tb_timer_ctrl;

  localparam int WIDTH     = 16;
  localparam int REP_WIDTH = 8;
  localparam int REP_MAX   = 255;

  logic                 clk_i;
  logic                 a_rst_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 pause_i;
  logic                 mode_i;
  logic [WIDTH-1:0]     period_i;
  logic [REP_WIDTH-1:0] repeat_i;
  logic                 busy_o;
  logic                 tick_o;
  logic                 done_o;
  logic                 err_o;
  logic [WIDTH-1:0]     val_o;
  logic [REP_WIDTH-1:0] rep_cnt_o;

  timer_ctrl #(.WIDTH(WIDTH), .REP_WIDTH(REP_WIDTH)) dut (
    .clk_i     (clk_i),
    .a_rst_i   (a_rst_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .pause_i   (pause_i),
    .mode_i    (mode_i),
    .period_i  (period_i),
    .repeat_i  (repeat_i),
    .busy_o    (busy_o),
    .tick_o    (tick_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .val_o     (val_o),
    .rep_cnt_o (rep_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit start; bit stop; bit pause; bit mode; int period; int rpt;
    bit busy; bit tick; bit done; bit err; int val; int rep;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural timer: active/paused flags, position in period, tick tally.
  bit m_act, m_pau, m_don, m_err, m_one;
  int m_val, m_rep, m_per, m_rpt;

  function automatic vec_t mk(bit s, bit st, bit p, bit m, int per, int r,
                              bit eb, bit et, bit ed, bit ee, int ev, int er);
    vec_t v;
    v.start = s; v.stop = st; v.pause = p; v.mode = m; v.period = per; v.rpt = r;
    v.busy = eb; v.tick = et; v.done = ed; v.err = ee; v.val = ev; v.rep = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pau = 0; m_don = 0; m_err = 0; m_one = 0;
    m_val = 0; m_rep = 0; m_per = 0; m_rpt = 0;
  endtask

  function automatic bit model_tick(input vec_t v);
    return m_act && !m_pau && !v.stop && !v.pause && (m_val == m_per - 1);
  endfunction

  task automatic model_step(input vec_t v);
    bit tk;
    tk = model_tick(v);
    m_err = 0;
    if (m_don) begin
      m_don = 0;
    end else if (!m_act) begin
      if (v.start && !v.stop) begin
        if (v.period != 0) begin
          m_per = v.period; m_one = (v.mode == 1'b0); m_rpt = v.rpt;
          m_val = 0; m_rep = 0; m_act = 1; m_pau = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (v.stop) begin
      m_act = 0; m_pau = 0; m_val = 0;
    end else if (m_pau) begin
      if (!v.pause) m_pau = 0;
    end else if (v.pause) begin
      m_pau = 1;
    end else if (tk) begin
      m_val = 0;
      if (m_rep < REP_MAX) m_rep++;
      if (m_one || (m_rpt != 0 && m_rep == m_rpt)) begin
        m_act = 0; m_don = 1;
      end
    end else begin
      m_val++;
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic apply(input vec_t v, input bit use_tbl, output bit tk, output bit dn);
    bit eb, et, ed, ee;
    int ev, er;
    @(negedge clk_i);
    start_i  = v.start;
    stop_i   = v.stop;
    pause_i  = v.pause;
    mode_i   = v.mode;
    period_i = WIDTH'(v.period);
    repeat_i = REP_WIDTH'(v.rpt);
    #1;
    if (use_tbl) begin
      eb = v.busy; et = v.tick; ed = v.done; ee = v.err; ev = v.val; er = v.rep;
    end else begin
      eb = m_act; et = model_tick(v); ed = m_don; ee = m_err; ev = m_val; er = m_rep;
    end
    chk("busy_o",    busy_o,    eb);
    chk("tick_o",    tick_o,    et);
    chk("done_o",    done_o,    ed);
    chk("err_o",     err_o,     ee);
    chk("val_o",     val_o,     ev);
    chk("rep_cnt_o", rep_cnt_o, er);
    tk = tick_o;
    dn = done_o;
    model_step(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_tick"}, tick_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"},  err_o,  0);
    chk({tag, "_val"},  val_o,  0);
    chk({tag, "_rep"},  rep_cnt_o, 0);
  endtask

  initial begin
    vec_t tbl[$];
    bit tk, dn;

    a_rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
    mode_i = 1'b0; period_i = '0; repeat_i = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    a_rst_i = 1'b0;

    // One-shot period 3 (start ignored in DONE), zero-period error,
    // start+stop no-op, period 1 periodic repeat 2.
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,3,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,3,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,3,0, 1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,3,0, 1,1,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,3,0, 0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,1));
    tbl.push_back(mk(1,1,0,1,5,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,1,1,2, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,1,2, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,2, 1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,1,2, 0,0,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,1,2, 0,0,0,0,0,2));
    foreach (tbl[i]) apply(tbl[i], 1'b1, tk, dn);

    // Periodic bounded: period 4, repeat 3, a start during RUN is ignored.
    for (int i = 0; i < 16; i++) begin
      apply(mk(i == 0 || i == 6, 0, 0, 1, 4, 3, 0,0,0,0,0,0), 1'b0, tk, dn);
      chk("bounded_tick_at", tk, (i == 4 || i == 8 || i == 12));
      chk("bounded_done_at", dn, (i == 13));
    end
    chk("bounded_rep_held", rep_cnt_o, 3);

    // Pause at val 2 for 6 cycles, then stop after the next tick.
    for (int i = 0; i < 15; i++) begin
      apply(mk(i == 0, i == 13, (i >= 3 && i <= 8), 1, 5, 0, 0,0,0,0,0,0), 1'b0, tk, dn);
      if (i >= 1 && i <= 12) chk("pause_tick_at", tk, (i == 12));
      if (i >= 4 && i <= 10) chk("pause_val_hold", val_o, (i <= 10) ? 2 : 0);
      chk("pause_no_done", dn, 0);
    end
    chk("stop_busy", busy_o, 0);
    chk("stop_val", val_o, 0);
    chk("stop_rep", rep_cnt_o, 1);

    // Asynchronous reset while running, period 10, at val 4.
    for (int i = 0; i < 5; i++) apply(mk(i == 0, 0, 0, 0, 10, 0, 0,0,0,0,0,0), 1'b0, tk, dn);
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
    #1;
    chk("midrun_val", val_o, 4);
    #2;
    a_rst_i = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    @(posedge clk_i);
    #1;
    chk("midrun_post_tick", tick_o, 0);
    chk("midrun_post_busy", busy_o, 0);
    @(negedge clk_i);
    a_rst_i = 1'b0;
    model_reset();

    // Randomized commands against the model.
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      int per;
      per = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      v = mk($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             per, int'($urandom_range(0, 3)), 0,0,0,0,0,0);
      apply(v, 1'b0, tk, dn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
